pc_fetch_seq: RTL and testbench

- Front-end producer for the valid/PC pipeline.
- Generates the stage-0 valid bit (pc_en) and the stage-0 PC (pc0) that the 6-stage valid/PC pipeline consumes.
- Accepts the same redirect events the pipeline uses to kill stages: br (early branch) and br_c (late correction). On a redirect it reloads the PC from the supplied target and inserts bubbles.
- Shares the pipeline's global stall enable, so front end and pipeline advance in lockstep.

---
 rtl/pc_fetch_seq_pkg.sv | 16 +
 rtl/pc_fetch_seq_if.sv | 28 ++
 rtl/pc_fetch_seq_bubble_ctr.sv | 26 ++
 rtl/pc_fetch_seq.sv | 114 +++++++++++
 tb/tb_pc_fetch_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the valid/PC pipeline front end and its consumers.
// Holds the fetch FSM state encoding and pipeline-wide constants.
package pc_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALTED = 2'd3
  } pc_state_e;

  localparam int unsigned PC_WIDTH_DEF = 16;
  localparam int unsigned PC_INC_DEF   = 1;
  localparam int unsigned N_STAGES     = 6;

endpackage

// File: rtl/pc_fetch_seq_if.sv
// Control/redirect inputs and stage-0 outputs of the fetch sequencer.
// The master side is the pipeline control; the slave side is the sequencer.
interface pc_fetch_seq_if #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 en;
  logic                 start;
  logic                 halt_req;
  logic                 br;
  logic [PC_WIDTH-1:0]  br_target;
  logic                 br_c;
  logic [PC_WIDTH-1:0]  br_c_target;
  logic                 pc_en;
  logic [PC_WIDTH-1:0]  pc0;
  logic                 busy;
  logic [CNT_WIDTH-1:0] redirect_cnt;

  modport master (
    output en, start, halt_req, br, br_target, br_c, br_c_target,
    input  pc_en, pc0, busy, redirect_cnt
  );

  modport slave (
    input  en, start, halt_req, br, br_target, br_c, br_c_target,
    output pc_en, pc0, busy, redirect_cnt
  );
endinterface

// File: rtl/pc_fetch_seq_bubble_ctr.sv
// 3-bit loadable down-counter used to time post-redirect bubbles.
// Load wins over decrement; the count stops at zero.
module pc_bubble_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [2:0] i_load_val,
  output logic       o_zero
);

  logic [2:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pc_fetch_seq.sv
// Stage-0 producer for the valid/PC pipeline: sequential fetch, halt/resume,
// and br/br_c redirects with a fixed bubble count, all gated by the shared en.
module pc_fetch_seq
  import pc_pipe_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned PC_INC    = PC_INC_DEF,
  parameter int unsigned BUBBLES   = 1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic r_,
  pc_fetch_seq_if.slave bus
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_INC_V   = PC_WIDTH'(PC_INC);
  // The counter holds the bubbles still owed after the one emitted on the
  // redirect edge, so BUBBLE exits on the cycle it reads zero.
  localparam logic [2:0] BUBBLE_LOAD = 3'((BUBBLES == 0) ? 0 : BUBBLES - 1);

  pc_state_e            r_state;
  logic [PC_WIDTH-1:0]  r_pc0;
  logic                 r_pc_en;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_redir_cnt;

  logic                w_redir;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_bub_zero;

  assign w_redir  = bus.en && (bus.br || bus.br_c) && (r_state != IDLE);
  assign w_target = bus.br_c ? bus.br_c_target : bus.br_target;

  pc_bubble_ctr u_bubble_ctr (
    .clk        (clk),
    .rst_n      (r_),
    .i_load     (w_redir),
    .i_en       (bus.en && (r_state == BUBBLE)),
    .i_load_val (BUBBLE_LOAD),
    .o_zero     (w_bub_zero)
  );

  always_ff @(posedge clk or negedge r_) begin
    if (!r_) begin
      r_state     <= IDLE;
      r_pc0       <= RESET_PC_V;
      r_pc_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_redir_cnt <= '0;
    end else if (bus.en) begin
      if (w_redir) begin
        r_pc0 <= w_target;
        if (r_redir_cnt != '1) begin
          r_redir_cnt <= r_redir_cnt + CNT_WIDTH'(1);
        end
        if (r_state == HALTED) begin
          r_pc_en <= 1'b0;
          r_busy  <= 1'b0;
        end else if (BUBBLES == 0) begin
          r_state <= RUN;
          r_pc_en <= 1'b1;
          r_busy  <= 1'b1;
        end else begin
          r_state <= BUBBLE;
          r_pc_en <= 1'b0;
          r_busy  <= 1'b1;
        end
      end else begin
        unique case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_state <= RUN;
              r_pc_en <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          RUN: begin
            if (bus.halt_req) begin
              r_state <= HALTED;
              r_pc_en <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_pc0   <= r_pc0 + PC_INC_V;
              r_pc_en <= 1'b1;
            end
          end
          BUBBLE: begin
            if (w_bub_zero) begin
              r_state <= RUN;
              r_pc_en <= 1'b1;
            end else begin
              r_pc_en <= 1'b0;
            end
          end
          HALTED: begin
            if (bus.start) begin
              r_state <= RUN;
              r_pc_en <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.pc_en        = r_pc_en;
  assign bus.pc0          = r_pc0;
  assign bus.busy         = r_busy;
  assign bus.redirect_cnt = r_redir_cnt;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with BUBBLES = 1, RESET_PC = 0, PC_INC = 1.
// Expected values are hand-traced from the fetch/redirect/halt behaviour.
module tb_pc_fetch_seq;

  logic clk;
  logic r_;
  int unsigned n_tests;
  int unsigned n_fail;

  pc_fetch_seq_if #(.PC_WIDTH(16), .CNT_WIDTH(8)) bus ();

  pc_fetch_seq #(
    .PC_WIDTH  (16),
    .RESET_PC  (0),
    .PC_INC    (1),
    .BUBBLES   (1),
    .CNT_WIDTH (8)
  ) dut (
    .clk (clk),
    .r_  (r_),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect4(input string tag, input logic e_en, input logic [15:0] e_pc,
                         input logic e_busy, input logic [7:0] e_cnt);
    check({tag, ".pc_en"}, 32'(bus.pc_en), 32'(e_en));
    check({tag, ".pc0"}, 32'(bus.pc0), 32'(e_pc));
    check({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
    check({tag, ".cnt"}, 32'(bus.redirect_cnt), 32'(e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    r_ = 1'b0;
    bus.en = 1'b0; bus.start = 1'b0; bus.halt_req = 1'b0;
    bus.br = 1'b0; bus.br_c = 1'b0;
    bus.br_target = '0; bus.br_c_target = '0;

    #3;
    expect4("reset", 1'b0, 16'h0000, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    r_ = 1'b1;
    step();

    // Redirect in IDLE is ignored and not counted
    bus.en = 1'b1; bus.br = 1'b1; bus.br_target = 16'h0099;
    step();
    bus.br = 1'b0;
    expect4("idle_br", 1'b0, 16'h0000, 1'b0, 8'd0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    expect4("start", 1'b1, 16'h0000, 1'b1, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect4("run_seq", 1'b1, 16'(i), 1'b1, 8'd0);
    end
    for (int i = 0; i < 13; i++) step();
    expect4("run_0x10", 1'b1, 16'h0010, 1'b1, 8'd0);

    bus.br = 1'b1; bus.br_target = 16'h0100;
    step();
    bus.br = 1'b0;
    expect4("br_bubble", 1'b0, 16'h0100, 1'b1, 8'd1);
    step();
    expect4("br_issue", 1'b1, 16'h0100, 1'b1, 8'd1);
    step();
    expect4("br_next", 1'b1, 16'h0101, 1'b1, 8'd1);

    bus.br = 1'b1; bus.br_target = 16'h0200;
    bus.br_c = 1'b1; bus.br_c_target = 16'h0300;
    step();
    bus.br = 1'b0; bus.br_c = 1'b0;
    expect4("brc_prio", 1'b0, 16'h0300, 1'b1, 8'd2);
    step();
    expect4("brc_issue", 1'b1, 16'h0300, 1'b1, 8'd2);

    bus.br = 1'b1; bus.br_target = 16'h0004;
    step();
    bus.br = 1'b0;
    expect4("to4_bubble", 1'b0, 16'h0004, 1'b1, 8'd3);
    step();
    step();
    expect4("at5", 1'b1, 16'h0005, 1'b1, 8'd3);

    bus.en = 1'b0; bus.br = 1'b1; bus.br_target = 16'h0777;
    bus.halt_req = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect4("en0_hold", 1'b1, 16'h0005, 1'b1, 8'd3);
    end
    bus.en = 1'b1; bus.br = 1'b0; bus.halt_req = 1'b0;
    step();
    bus.start = 1'b0;
    expect4("en1_resume", 1'b1, 16'h0006, 1'b1, 8'd3);

    bus.br = 1'b1; bus.br_target = 16'hFFFE;
    step();
    bus.br = 1'b0;
    expect4("wrap_bubble", 1'b0, 16'hFFFE, 1'b1, 8'd4);
    step();
    expect4("wrap_fffe", 1'b1, 16'hFFFE, 1'b1, 8'd4);
    step();
    expect4("wrap_ffff", 1'b1, 16'hFFFF, 1'b1, 8'd4);
    step();
    expect4("wrap_0000", 1'b1, 16'h0000, 1'b1, 8'd4);
    step();
    expect4("wrap_0001", 1'b1, 16'h0001, 1'b1, 8'd4);

    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    expect4("halt", 1'b0, 16'h0001, 1'b0, 8'd4);
    step();
    expect4("halt_hold", 1'b0, 16'h0001, 1'b0, 8'd4);

    bus.br = 1'b1; bus.br_target = 16'h0040;
    step();
    bus.br = 1'b0;
    expect4("halt_br", 1'b0, 16'h0040, 1'b0, 8'd5);
    step();
    expect4("halt_br_stay", 1'b0, 16'h0040, 1'b0, 8'd5);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    expect4("resume", 1'b1, 16'h0040, 1'b1, 8'd5);
    step();
    expect4("resume_next", 1'b1, 16'h0041, 1'b1, 8'd5);

    bus.halt_req = 1'b1; bus.br = 1'b1; bus.br_target = 16'h0050;
    step();
    bus.halt_req = 1'b0; bus.br = 1'b0;
    expect4("br_over_halt", 1'b0, 16'h0050, 1'b1, 8'd6);
    step();
    expect4("halt_dropped", 1'b1, 16'h0050, 1'b1, 8'd6);
    step();
    expect4("halt_dropped2", 1'b1, 16'h0051, 1'b1, 8'd6);

    bus.br = 1'b1; bus.br_target = 16'h0060;
    step();
    expect4("bub_restart_a", 1'b0, 16'h0060, 1'b1, 8'd7);
    bus.br_target = 16'h0070;
    step();
    bus.br = 1'b0;
    expect4("bub_restart_b", 1'b0, 16'h0070, 1'b1, 8'd8);
    step();
    expect4("bub_restart_issue", 1'b1, 16'h0070, 1'b1, 8'd8);

    bus.br = 1'b1; bus.br_target = 16'h0123;
    step();
    bus.br = 1'b0;
    expect4("pre_rst_bubble", 1'b0, 16'h0123, 1'b1, 8'd9);
    #2;
    r_ = 1'b0;
    #1;
    expect4("async_rst", 1'b0, 16'h0000, 1'b0, 8'd0);
    @(negedge clk);
    r_ = 1'b1;
    step();
    expect4("post_rst_idle", 1'b0, 16'h0000, 1'b0, 8'd0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.br = 1'b1; bus.br_target = 16'h0200;
    for (int i = 0; i < 255; i++) step();
    check("sat_255", 32'(bus.redirect_cnt), 32'd255);
    for (int i = 0; i < 45; i++) step();
    check("sat_300", 32'(bus.redirect_cnt), 32'd255);
    bus.br = 1'b0;
    step();
    expect4("sat_issue", 1'b1, 16'h0200, 1'b1, 8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
